// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts one byte plus odd parity out on device clock edges and checks the ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int REQ_CYCLES     = 200,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  clk_sync_q, data_sync_q;
    logic        clk_prev_q;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  n_q, n_d;
    logic [8:0]  frame_q, frame_d;   // {parity, byte}
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic clk_s, data_s, fe, timeout;

    assign clk_s   = clk_sync_q[1];
    assign data_s  = data_sync_q[1];
    assign fe      = clk_prev_q & ~clk_s;
    assign timeout = (cnt_q == 32'(TIMEOUT_CYCLES - 1));

    // Synchronizers idle high so a reset release never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            frame_q     <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_prev_q  <= clk_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            frame_q     <= frame_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        n_d     = n_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                n_d   = '0;
                if (tx_start) begin
                    frame_d = {~^tx_data, tx_data};
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == 32'(INHIBIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (cnt_q == 32'(REQ_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (fe) begin
                    cnt_d = '0;
                    n_d   = n_q + 4'd1;
                    if (n_q == 4'd9) state_d = S_ACK;
                end else if (timeout) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                if (fe) begin
                    cnt_d = '0;
                    if (data_s) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end else if (timeout) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (fe) cnt_d = '0;
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (timeout && !fe) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line drive decodes straight from state so reset releases the bus immediately.
    always_comb begin
        ps2_data_oe = 1'b0;
        case (state_q)
            S_REQ:  ps2_data_oe = 1'b1;
            S_SEND: begin
                if (n_q == 4'd0) ps2_data_oe = 1'b1;
                else             ps2_data_oe = ~frame_q[n_q - 4'd1];
            end
            default: ps2_data_oe = 1'b0;
        endcase
    end

    assign ps2_clk_oe = (state_q == S_INHIBIT) || (state_q == S_REQ);
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign error      = error_q;

endmodule
